// File: rtl/mem_wb_stage.sv
// Memory-access and write-back stage: byte-addressed data memory with lane
// steering, load extraction, misalignment detection and the W pipeline register.
module mem_wb_stage #(
  parameter int DMEM_WORDS = 256
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        write_enable_RF_M,
  input  logic        write_enable_dmem_M,
  input  logic [1:0]  write_back_M,
  input  logic [31:0] alu_rsl_M,
  input  logic [31:0] imm_extended_M,
  input  logic [31:0] wd_M,
  input  logic [31:0] pc4_M,
  input  logic [4:0]  rd_M,
  input  logic [2:0]  store_sel_M,
  input  logic [2:0]  load_sel_M,
  output logic        write_enable_RF_W,
  output logic [4:0]  rd_W,
  output logic [31:0] result_W,
  output logic        misalign_M,
  output logic        misalign_W
);

  localparam int AW = $clog2(DMEM_WORDS);

  logic [31:0]   dmem [DMEM_WORDS];
  logic [AW-1:0] word_idx;
  logic [31:0]   rdata;
  logic [1:0]    lane;

  logic          is_load;
  logic          store_mis;
  logic          load_mis;
  logic [3:0]    byte_en;
  logic [31:0]   wdata_lanes;
  logic          dmem_wr;
  logic [7:0]    lane_byte;
  logic [15:0]   lane_half;
  logic [31:0]   load_data;

  logic [1:0]    wb_w;
  logic [31:0]   alu_w;
  logic [31:0]   load_w;
  logic [31:0]   pc4_w;
  logic [31:0]   imm_w;

  assign word_idx = alu_rsl_M[AW+1:2];
  assign lane     = alu_rsl_M[1:0];
  assign rdata    = dmem[word_idx];

  always_comb begin
    is_load     = (write_back_M == 2'b01);
    store_mis   = 1'b0;
    byte_en     = 4'b0000;
    wdata_lanes = wd_M;
    case (store_sel_M)
      3'b000: begin
        byte_en     = 4'b0001 << lane;
        wdata_lanes = {4{wd_M[7:0]}};
      end
      3'b001: begin
        store_mis   = lane[0];
        byte_en     = lane[1] ? 4'b1100 : 4'b0011;
        wdata_lanes = {2{wd_M[15:0]}};
      end
      3'b010: begin
        store_mis = |lane;
        byte_en   = 4'b1111;
      end
      default: byte_en = 4'b0000;
    endcase

    load_mis = 1'b0;
    case (load_sel_M)
      3'b001, 3'b101: load_mis = lane[0];
      3'b010:         load_mis = |lane;
      default:        load_mis = 1'b0;
    endcase

    misalign_M = (write_enable_dmem_M & store_mis) | (is_load & load_mis);
    dmem_wr    = write_enable_dmem_M & ~rst & ~misalign_M;
  end

  // Read data is the pre-store word, so extraction never sees a same-cycle store.
  always_comb begin
    lane_byte = rdata[8*lane +: 8];
    lane_half = lane[1] ? rdata[31:16] : rdata[15:0];
    load_data = 32'd0;
    if (!load_mis) begin
      case (load_sel_M)
        3'b000:  load_data = {{24{lane_byte[7]}}, lane_byte};
        3'b001:  load_data = {{16{lane_half[15]}}, lane_half};
        3'b010:  load_data = rdata;
        3'b100:  load_data = {24'd0, lane_byte};
        3'b101:  load_data = {16'd0, lane_half};
        default: load_data = 32'd0;
      endcase
    end
  end

  // Memory is deliberately not reset; only the write strobe is gated.
  always_ff @(posedge clk) begin
    if (dmem_wr) begin
      for (int b = 0; b < 4; b++) begin
        if (byte_en[b]) dmem[word_idx][8*b +: 8] <= wdata_lanes[8*b +: 8];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      write_enable_RF_W <= 1'b0;
      rd_W              <= 5'd0;
      wb_w              <= 2'b00;
      alu_w             <= 32'd0;
      load_w            <= 32'd0;
      pc4_w             <= 32'd0;
      imm_w             <= 32'd0;
      misalign_W        <= 1'b0;
    end else begin
      write_enable_RF_W <= write_enable_RF_M & ~(is_load & load_mis);
      rd_W              <= rd_M;
      wb_w              <= write_back_M;
      alu_w             <= alu_rsl_M;
      load_w            <= load_data;
      pc4_w             <= pc4_M;
      imm_w             <= imm_extended_M;
      if (misalign_M) misalign_W <= 1'b1;
    end
  end

  always_comb begin
    case (wb_w)
      2'b00:   result_W = alu_w;
      2'b01:   result_W = load_w;
      2'b10:   result_W = pc4_w;
      default: result_W = imm_w;
    endcase
  end

endmodule

// File: tb/tb_mem_wb_stage.sv
// Scoreboard bench for mem_wb_stage: directed M-stage vectors push expected
// W outputs into a queue; a monitor pops and compares one cycle later.
module tb_mem_wb_stage;

  logic        clk = 1'b0;
  logic        rst;
  logic        write_enable_RF_M;
  logic        write_enable_dmem_M;
  logic [1:0]  write_back_M;
  logic [31:0] alu_rsl_M;
  logic [31:0] imm_extended_M;
  logic [31:0] wd_M;
  logic [31:0] pc4_M;
  logic [4:0]  rd_M;
  logic [2:0]  store_sel_M;
  logic [2:0]  load_sel_M;
  logic        write_enable_RF_W;
  logic [4:0]  rd_W;
  logic [31:0] result_W;
  logic        misalign_M;
  logic        misalign_W;

  mem_wb_stage #(.DMEM_WORDS(256)) dut (
    .clk                 (clk),
    .rst                 (rst),
    .write_enable_RF_M   (write_enable_RF_M),
    .write_enable_dmem_M (write_enable_dmem_M),
    .write_back_M        (write_back_M),
    .alu_rsl_M           (alu_rsl_M),
    .imm_extended_M      (imm_extended_M),
    .wd_M                (wd_M),
    .pc4_M               (pc4_M),
    .rd_M                (rd_M),
    .store_sel_M         (store_sel_M),
    .load_sel_M          (load_sel_M),
    .write_enable_RF_W   (write_enable_RF_W),
    .rd_W                (rd_W),
    .result_W            (result_W),
    .misalign_M          (misalign_M),
    .misalign_W          (misalign_W)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        we;
    logic [4:0]  rd;
    logic [31:0] res;
    logic        mis;
    string       nm;
  } exp_t;

  exp_t q[$];
  int   checks = 0;
  int   errors = 0;
  logic exp_mis_w = 1'b0;

  // Monitor: W outputs settle #1 after each rising edge.
  always @(posedge clk) begin
    #1;
    if (q.size() > 0) begin
      exp_t e;
      e = q.pop_front();
      checks += 4;
      if (write_enable_RF_W !== e.we) begin
        errors++;
        $display("FAIL %s we_W: got %0b want %0b", e.nm, write_enable_RF_W, e.we);
      end
      if (rd_W !== e.rd) begin
        errors++;
        $display("FAIL %s rd_W: got %0d want %0d", e.nm, rd_W, e.rd);
      end
      if (result_W !== e.res) begin
        errors++;
        $display("FAIL %s result_W: got %08h want %08h", e.nm, result_W, e.res);
      end
      if (misalign_W !== e.mis) begin
        errors++;
        $display("FAIL %s misalign_W: got %0b want %0b", e.nm, misalign_W, e.mis);
      end
    end
  end

  task automatic issue(input string nm, input bit r, input bit we_rf, input bit we_dm,
                       input bit [1:0] wb, input logic [31:0] alu, input logic [31:0] wd,
                       input logic [31:0] pc4, input logic [31:0] imm, input bit [4:0] rd,
                       input bit [2:0] ss, input bit [2:0] ls,
                       input logic [31:0] exp_res, input bit exp_mis_m);
    exp_t e;
    @(negedge clk);
    rst                 = r;
    write_enable_RF_M   = we_rf;
    write_enable_dmem_M = we_dm;
    write_back_M        = wb;
    alu_rsl_M           = alu;
    wd_M                = wd;
    pc4_M               = pc4;
    imm_extended_M      = imm;
    rd_M                = rd;
    store_sel_M         = ss;
    load_sel_M          = ls;
    #1;
    checks++;
    if (misalign_M !== exp_mis_m) begin
      errors++;
      $display("FAIL %s misalign_M: got %0b want %0b", nm, misalign_M, exp_mis_m);
    end
    if (r) begin
      exp_mis_w = 1'b0;
      e = '{we: 1'b0, rd: 5'd0, res: 32'd0, mis: 1'b0, nm: nm};
    end else begin
      exp_mis_w = exp_mis_w | exp_mis_m;
      e = '{we: we_rf && !(wb == 2'b01 && exp_mis_m), rd: rd, res: exp_res,
            mis: exp_mis_w, nm: nm};
    end
    q.push_back(e);
  endtask

  // Shorthands: store uses write_back 00 so result_W is the address.
  task automatic st(input string nm, input bit [2:0] ss, input logic [31:0] a,
                    input logic [31:0] wd, input bit mis);
    issue(nm, 0, 0, 1, 2'b00, a, wd, 32'd0, 32'd0, 5'd0, ss, 3'b010, a, mis);
  endtask

  task automatic ld(input string nm, input bit [2:0] ls, input logic [31:0] a,
                    input bit [4:0] rd, input logic [31:0] exp_res, input bit mis);
    issue(nm, 0, 1, 0, 2'b01, a, 32'd0, 32'd0, 32'd0, rd, 3'b010, ls, exp_res, mis);
  endtask

  initial begin
    rst = 1'b1;
    write_enable_RF_M = 0; write_enable_dmem_M = 0; write_back_M = 0;
    alu_rsl_M = 0; wd_M = 0; pc4_M = 0; imm_extended_M = 0; rd_M = 0;
    store_sel_M = 0; load_sel_M = 0;
    repeat (2) @(negedge clk);

    issue("reset", 1, 1, 0, 2'b11, 32'h0, 32'h0, 32'h4, 32'h55, 5'd3, 3'b000, 3'b000, 32'h0, 1'b0);

    st("sw_dead",  3'b010, 32'h10, 32'hDEADBEEF, 0);
    ld("lw_dead",  3'b010, 32'h10, 5'd5, 32'hDEADBEEF, 0);

    st("sw_zero",  3'b010, 32'h10, 32'h0, 0);
    st("sb_f0",    3'b000, 32'h11, 32'h000000F0, 0);
    ld("lw_f000",  3'b010, 32'h10, 5'd6, 32'h0000F000, 0);
    ld("lb_f0",    3'b000, 32'h11, 5'd6, 32'hFFFFFFF0, 0);
    ld("lbu_f0",   3'b100, 32'h11, 5'd6, 32'h000000F0, 0);
    ld("lb_lane0", 3'b000, 32'h10, 5'd6, 32'h00000000, 0);

    st("sw_aa55",  3'b010, 32'h20, 32'hAAAA5555, 0);
    st("sh_8001",  3'b001, 32'h22, 32'h00008001, 0);
    ld("lh_8001",  3'b001, 32'h22, 5'd8, 32'hFFFF8001, 0);
    ld("lhu_8001", 3'b101, 32'h22, 5'd8, 32'h00008001, 0);
    ld("lw_8001",  3'b010, 32'h20, 5'd8, 32'h80015555, 0);
    ld("lhu_low",  3'b101, 32'h20, 5'd8, 32'h00005555, 0);

    st("st_undef", 3'b011, 32'h20, 32'hFFFFFFFF, 0);
    ld("lw_kept",  3'b010, 32'h20, 5'd9, 32'h80015555, 0);
    ld("ld_undef", 3'b011, 32'h20, 5'd9, 32'h00000000, 0);

    ld("lw_mis",   3'b010, 32'h13, 5'd7, 32'h00000000, 1);
    st("sw_mis",   3'b010, 32'h12, 32'h12345678, 1);
    ld("lw_unchg", 3'b010, 32'h10, 5'd7, 32'h0000F000, 0);
    ld("lh_mis",   3'b001, 32'h21, 5'd7, 32'h00000000, 1);

    issue("pc4", 0, 1, 0, 2'b10, 32'h40, 32'h0, 32'h104, 32'h0, 5'd3, 3'b111, 3'b010, 32'h104, 1'b0);
    issue("imm", 0, 1, 0, 2'b11, 32'h40, 32'h0, 32'h0, 32'h12345000, 5'd4, 3'b111, 3'b010, 32'h12345000, 1'b0);

    st("sw_wrap",  3'b010, 32'h410, 32'hCAFEF00D, 0);
    ld("lw_wrap",  3'b010, 32'h10, 5'd10, 32'hCAFEF00D, 0);
    st("sb_hi",    3'b000, 32'h13, 32'h000000AB, 0);
    ld("lbu_hi",   3'b100, 32'h13, 5'd10, 32'h000000AB, 0);

    issue("rst_sw", 1, 1, 1, 2'b00, 32'h10, 32'h55555555, 32'h0, 32'h0, 5'd9, 3'b010, 3'b010, 32'h0, 1'b0);
    ld("lw_postrst", 3'b010, 32'h10, 5'd11, 32'hABFEF00D, 0);

    @(negedge clk);
    write_enable_RF_M = 0; write_enable_dmem_M = 0; write_back_M = 0;
    begin
      int n;
      n = 0;
      while (q.size() > 0 && n < 10) begin
        @(negedge clk);
        n++;
      end
    end
    if (q.size() > 0) begin
      errors++;
      $display("FAIL drain: %0d expectations left, want 0", q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
